sc_screen_mode_sequencer: RTL and testbench

Sequencing controller for the 4:1 screen-content multiplexer in the RoadFighter video path. Owns the mux select bus and steps the display through power-up clear, attract fill, live road (random) content, crash blink and game-over hold. Timing comes from a once-per-frame tick, and game events arrive as one-cycle pulses from the game logic. Sits between the game FSM and the screen mux; it is the only driver of the mux select.

---
 rtl/sc_scrseq_pkg.sv | 19 +
 rtl/sc_frame_counter.sv | 28 ++
 rtl/sc_screen_mode_sequencer.sv | 98 +++++++++
 tb/tb_sc_screen_mode_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_scrseq_pkg.sv
// Shared encodings for the screen-mode sequencer.
// State codes and mux select codes.
package sc_scrseq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_BLINK = 3'd3,
    ST_OVER  = 3'd4
  } scState_t;

  localparam logic [1:0] SEL_ZEROS  = 2'd0;
  localparam logic [1:0] SEL_ONES   = 2'd1;
  localparam logic [1:0] SEL_RANDOM = 2'd2;

endpackage

// File: rtl/sc_frame_counter.sv
// Frame tick counter with sync clear and terminal flag.
// tc fires on the tick that reaches terminal; count then wraps.
module sc_frame_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] terminal,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] count;

  assign tc = en && (count == terminal - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sc_screen_mode_sequencer.sv
// Screen-mode sequencer: owns the 4:1 screen mux select.
// Clear -> idle -> play -> crash blink -> game over.
module sc_screen_mode_sequencer
  import sc_scrseq_pkg::*;
#(
  parameter int SELECT_WIDTH = 8,
  parameter int CNT_WIDTH    = 8,
  parameter int CLEAR_FRAMES = 4,
  parameter int BLINK_FRAMES = 8,
  parameter int BLINK_PERIOD = 2
) (
  input  logic                    SC_SCRSEQ_CLOCK_50,
  input  logic                    SC_SCRSEQ_RESET_InLow,
  input  logic                    SC_SCRSEQ_frameTick_In,
  input  logic                    SC_SCRSEQ_start_In,
  input  logic                    SC_SCRSEQ_crash_In,
  output logic [SELECT_WIDTH-1:0] SC_SCRSEQ_select_OutBus,
  output logic                    SC_SCRSEQ_update_Out,
  output logic                    SC_SCRSEQ_playing_Out,
  output logic [STATE_W-1:0]      SC_SCRSEQ_state_OutBus
);

  scState_t state, stateNext;
  logic [SELECT_WIDTH-1:0] selNext;
  logic [CNT_WIDTH-1:0] totalTerm;
  logic stateChg, totalTc, phaseTc;
  logic countTotal, countPhase;

  assign stateChg   = stateNext != state;
  assign countTotal = SC_SCRSEQ_frameTick_In &&
                      (state == ST_CLEAR || state == ST_BLINK);
  assign countPhase = SC_SCRSEQ_frameTick_In && (state == ST_BLINK);
  assign totalTerm  = (state == ST_CLEAR) ? CNT_WIDTH'(CLEAR_FRAMES)
                                          : CNT_WIDTH'(BLINK_FRAMES);

  sc_frame_counter #(.CNT_WIDTH(CNT_WIDTH)) uTotal (
    .clk      (SC_SCRSEQ_CLOCK_50),
    .rst_n    (SC_SCRSEQ_RESET_InLow),
    .clr      (stateChg),
    .en       (countTotal),
    .terminal (totalTerm),
    .tc       (totalTc)
  );

  sc_frame_counter #(.CNT_WIDTH(CNT_WIDTH)) uPhase (
    .clk      (SC_SCRSEQ_CLOCK_50),
    .rst_n    (SC_SCRSEQ_RESET_InLow),
    .clr      (stateChg),
    .en       (countPhase),
    .terminal (CNT_WIDTH'(BLINK_PERIOD)),
    .tc       (phaseTc)
  );

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_CLEAR: if (totalTc) stateNext = ST_IDLE;
      ST_IDLE:  if (SC_SCRSEQ_start_In) stateNext = ST_PLAY;
      ST_PLAY:  if (SC_SCRSEQ_crash_In) stateNext = ST_BLINK;
      ST_BLINK: if (totalTc) stateNext = ST_OVER;
      ST_OVER:  if (SC_SCRSEQ_start_In) stateNext = ST_CLEAR;
      default:  stateNext = ST_CLEAR;
    endcase
  end

  // Blink select is bit 0 of the held select, flipped per half-cycle.
  always_comb begin
    selNext = SELECT_WIDTH'(SEL_ZEROS);
    unique case (1'b1)
      stateNext == ST_IDLE,
      stateNext == ST_OVER:
        selNext = SELECT_WIDTH'(SEL_ONES);
      stateNext == ST_PLAY:
        selNext = SELECT_WIDTH'(SEL_RANDOM);
      stateNext == ST_BLINK && state == ST_BLINK:
        selNext = SC_SCRSEQ_select_OutBus ^ SELECT_WIDTH'(phaseTc);
      default:
        selNext = SELECT_WIDTH'(SEL_ZEROS);
    endcase
  end

  always_ff @(posedge SC_SCRSEQ_CLOCK_50 or negedge SC_SCRSEQ_RESET_InLow) begin
    if (!SC_SCRSEQ_RESET_InLow) begin
      state                   <= ST_CLEAR;
      SC_SCRSEQ_select_OutBus <= '0;
      SC_SCRSEQ_update_Out    <= 1'b0;
      SC_SCRSEQ_playing_Out   <= 1'b0;
    end else begin
      state                   <= stateNext;
      SC_SCRSEQ_select_OutBus <= selNext;
      SC_SCRSEQ_update_Out    <= selNext != SC_SCRSEQ_select_OutBus;
      SC_SCRSEQ_playing_Out   <= stateNext == ST_PLAY;
    end
  end

  assign SC_SCRSEQ_state_OutBus = state;

endmodule

// File: tb/tb_sc_screen_mode_sequencer.sv
// Bench for sc_screen_mode_sequencer: tick-count model
// compared every cycle, plus literal pins on the game flow.
module tb_sc_screen_mode_sequencer;

  localparam int CF = 4;
  localparam int BF = 8;
  localparam int BP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic crash = 1'b0;
  logic [7:0] sel;
  logic upd;
  logic playing;
  logic [2:0] st;

  always #5 clk = ~clk;

  sc_screen_mode_sequencer #(
    .SELECT_WIDTH (8),
    .CNT_WIDTH    (8),
    .CLEAR_FRAMES (CF),
    .BLINK_FRAMES (BF),
    .BLINK_PERIOD (BP)
  ) dut (
    .SC_SCRSEQ_CLOCK_50      (clk),
    .SC_SCRSEQ_RESET_InLow   (rst_n),
    .SC_SCRSEQ_frameTick_In  (tick),
    .SC_SCRSEQ_start_In      (start),
    .SC_SCRSEQ_crash_In      (crash),
    .SC_SCRSEQ_select_OutBus (sel),
    .SC_SCRSEQ_update_Out    (upd),
    .SC_SCRSEQ_playing_Out   (playing),
    .SC_SCRSEQ_state_OutBus  (st)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: state plus ticks seen since entering it.
  int mSt, mTicks, mSel, nxt, newSel;
  bit mUpd;

  function automatic int selOf(input int s, input int t);
    case (s)
      0: return 0;
      2: return 2;
      3: return (t / BP) % 2;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSt = 0; mTicks = 0; mSel = 0; mUpd = 0;
    end else begin
      nxt = mSt;
      case (mSt)
        0: if (tick) begin
             mTicks++;
             if (mTicks == CF) nxt = 1;
           end
        1: if (start) nxt = 2;
        2: if (crash) nxt = 3;
        3: if (tick) begin
             mTicks++;
             if (mTicks == BF) nxt = 4;
           end
        default: if (start) nxt = 0;
      endcase
      if (nxt != mSt) begin
        mSt = nxt;
        mTicks = 0;
      end
      newSel = selOf(mSt, mTicks);
      mUpd = newSel != mSel;
      mSel = newSel;
    end
  end

  int updN = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_select", int'(sel), mSel);
      chk("model_update", int'(upd), int'(mUpd));
      chk("model_playing", int'(playing), int'(mSt == 2));
      chk("model_state", int'(st), mSt);
      if (upd) updN++;
    end
  end

  task automatic cyc(input bit t, input bit s, input bit c);
    @(negedge clk);
    tick = t; start = s; crash = c;
  endtask

  task automatic doFrame();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  int blinkExp[7] = '{0, 1, 1, 0, 0, 1, 1};

  task automatic game(input bit noisy);
    int u0;
    for (int i = 0; i < CF; i++) begin
      if (noisy && i == 1) cyc(1'b0, 1'b1, 1'b0);
      doFrame();
      if (i == CF - 2) chk("clear_hold_sel", int'(sel), 0);
    end
    chk("idle_state", int'(st), 1);
    chk("idle_sel", int'(sel), 1);
    chk("idle_upd", int'(upd), 1);
    if (noisy) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("idle_crash_ignored", int'(st), 1);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("play_state", int'(st), 2);
    chk("play_sel", int'(sel), 2);
    chk("play_playing", int'(playing), 1);
    chk("play_upd", int'(upd), 1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("play_start_ignored", int'(st), 2);
    chk("play_no_upd", int'(upd), 0);
    cyc(1'b0, 1'b1, 1'b1);
    u0 = updN;
    cyc(1'b0, 1'b0, 1'b0);
    chk("blink_state", int'(st), 3);
    chk("blink_sel", int'(sel), 0);
    chk("blink_playing", int'(playing), 0);
    chk("blink_upd", int'(upd), 1);
    for (int i = 0; i < BF; i++) begin
      if (noisy && i == 3) cyc(1'b0, 1'b1, 1'b0);
      doFrame();
      if (i < BF - 1) chk("blink_trace", int'(sel), blinkExp[i]);
    end
    chk("over_state", int'(st), 4);
    chk("over_sel", int'(sel), 1);
    chk("blink_upd_count", updN - u0, 4);
    if (noisy) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("over_crash_ignored", int'(st), 4);
    end
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart_state", int'(st), 0);
    chk("restart_sel", int'(sel), 0);
    chk("restart_upd", int'(upd), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", int'(st), 0);
    chk("reset_sel", int'(sel), 0);
    chk("reset_upd", int'(upd), 0);
    chk("reset_playing", int'(playing), 0);
    rst_n = 1'b1;
    game(1'b0);
    game(1'b1);
    repeat (CF) doFrame();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (2) doFrame();
    chk("pre_reset_blink", int'(st), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(st), 0);
    chk("async_sel", int'(sel), 0);
    chk("async_upd", int'(upd), 0);
    chk("async_playing", int'(playing), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < CF; i++) begin
      doFrame();
      if (i == CF - 2) chk("reclear_hold_sel", int'(sel), 0);
    end
    chk("reclear_state", int'(st), 1);
    chk("reclear_sel", int'(sel), 1);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
